// File: rtl/mem_wb_stage.sv
// MEM->WB stage register with a one-entry skid buffer; in->out latency is 1 cycle.
// in_ready is decoded from registered state only, so out_ready never reaches in_ready combinationally.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int LANES  = 7,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [RD_W-1:0]           in_rd,
  input  logic                      in_reg_wb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [RD_W-1:0]           out_rd,
  output logic                      out_reg_wb,
  output logic [CNT_W-1:0]          retired
);

  localparam int PW = LANES * DATA_W;

  typedef struct packed {
    logic [PW-1:0]   data;
    logic [RD_W-1:0] rd;
    logic            reg_wb;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  entry_t             in_entry;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               in_hs, out_hs;

  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign in_entry  = {in_data, in_rd, in_reg_wb};

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    retired_d = retired_q + CNT_W'(out_hs);

    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          main_d  = in_entry;
          state_d = FULL;
        end
      end
      FULL: begin
        if (in_hs && out_hs) begin
          main_d = in_entry;
        end else if (in_hs) begin
          skid_d  = in_entry;
          state_d = SKID;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush only kills held entries; a handshake in this cycle is still counted above.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      retired_q <= retired_d;
    end
  end

  assign out_data   = main_q.data;
  assign out_rd     = main_q.rd;
  assign out_reg_wb = main_q.reg_wb & out_valid;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors plus a scoreboard monitor, with a 4-bit counter
// instance sharing the main stimulus and a 1x64-bit lane instance driven with random traffic.
module tb_mem_wb_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid, in_ready;
  logic [223:0] in_data;
  logic [4:0]   in_rd;
  logic         in_reg_wb;
  logic         out_valid, out_ready;
  logic [223:0] out_data;
  logic [4:0]   out_rd;
  logic         out_reg_wb;
  logic [31:0]  retired;

  logic         w_in_ready, w_out_valid, w_out_reg_wb;
  logic [223:0] w_out_data;
  logic [4:0]   w_out_rd;
  logic [3:0]   w_retired;

  logic         p_flush = 1'b0;
  logic         p_in_valid, p_in_ready, p_in_reg_wb;
  logic [63:0]  p_in_data;
  logic [5:0]   p_in_rd;
  logic         p_out_valid, p_out_ready, p_out_reg_wb;
  logic [63:0]  p_out_data;
  logic [5:0]   p_out_rd;
  logic [31:0]  p_retired;

  int errors = 0;
  int checks = 0;
  int p_pops = 0;

  logic [229:0] q0[$];
  logic [70:0]  qp[$];
  logic [229:0] e0;
  logic [70:0]  ep;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_reg_wb(in_reg_wb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_reg_wb(out_reg_wb),
    .retired(retired)
  );

  mem_wb_stage #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_reg_wb(in_reg_wb),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_rd(w_out_rd), .out_reg_wb(w_out_reg_wb),
    .retired(w_retired)
  );

  mem_wb_stage #(.LANES(1), .DATA_W(64), .RD_W(6)) dut_p (
    .clk(clk), .reset(reset), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .in_rd(p_in_rd), .in_reg_wb(p_in_reg_wb),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .out_rd(p_out_rd), .out_reg_wb(p_out_reg_wb),
    .retired(p_retired)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] l0, input logic [4:0] rd, input logic wb);
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++)
      in_data[k*32 +: 32] = (k == 0) ? l0 : {8'(k), 8'h5A, l0[15:0]};
    in_rd     = rd;
    in_reg_wb = wb;
  endtask

  // Back-to-back entries with out_ready low; returns with the stage in SKID.
  task automatic to_skid(input logic [31:0] a, input logic [31:0] b, input logic wb);
    out_ready = 1'b0;
    drive(a, 5'd3, wb);
    step();
    drive(b, 5'd4, wb);
    step();
    in_valid = 1'b0;
  endtask

  task automatic stream(input logic [31:0] base, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        chk("stream_valid", 256'(out_valid), 256'(1));
        chk("stream_lane0", 256'(out_data[31:0]), 256'(base + 32'(i - 1)));
        chk("stream_rd", 256'(out_rd), 256'(i));
      end
      drive(base + 32'(i), 5'(i + 1), (i % 3) != 0);
      step();
    end
    in_valid = 1'b0;
    chk("stream_last", 256'(out_data[31:0]), 256'(base + 32'(n - 1)));
    step();
  endtask

  // Scoreboard: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      q0.delete();
      qp.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          chk("sb0_underflow", 256'(1), 256'(0));
        end else begin
          e0 = q0.pop_front();
          chk("sb0_entry", 256'({out_data, out_rd, out_reg_wb}), 256'(e0));
        end
      end
      if (flush) q0.delete();
      else if (in_valid && in_ready) q0.push_back({in_data, in_rd, in_reg_wb});

      if (p_out_valid && p_out_ready) begin
        p_pops++;
        if (qp.size() == 0) begin
          chk("sbp_underflow", 256'(1), 256'(0));
        end else begin
          ep = qp.pop_front();
          chk("sbp_entry", 256'({p_out_data, p_out_rd, p_out_reg_wb}), 256'(ep));
        end
      end
      if (p_in_valid && p_in_ready) qp.push_back({p_in_data, p_in_rd, p_in_reg_wb});
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; in_rd = '0; in_reg_wb = 1'b0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_data = '0; p_in_rd = '0; p_in_reg_wb = 1'b0; p_out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_retired", 256'(retired), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_out_rd", 256'(out_rd), 256'(0));
    chk("rst_out_reg_wb", 256'(out_reg_wb), 256'(0));
    reset = 1'b1;
    step();

    stream(32'h10, 8);
    chk("stream_retired", 256'(retired), 256'(8));
    chk("stream_w_retired", 256'(w_retired), 256'(8));
    chk("stream_drained", 256'(out_valid), 256'(0));

    to_skid(32'hAAAA, 32'hBBBB, 1'b0);
    chk("bp_in_ready", 256'(in_ready), 256'(0));
    chk("bp_out_valid", 256'(out_valid), 256'(1));
    chk("bp_hold_a", 256'(out_data[31:0]), 256'(32'hAAAA));
    step();
    chk("bp_still_a", 256'(out_data[31:0]), 256'(32'hAAAA));
    out_ready = 1'b1;
    step();
    chk("bp_then_b", 256'(out_data[31:0]), 256'(32'hBBBB));
    chk("bp_in_ready_back", 256'(in_ready), 256'(1));
    step();
    chk("bp_empty", 256'(out_valid), 256'(0));
    chk("bp_retired", 256'(retired), 256'(10));

    to_skid(32'hC, 32'hD, 1'b1);
    chk("fl0_reg_wb_before", 256'(out_reg_wb), 256'(1));
    flush = 1'b1;
    drive(32'hE, 5'd9, 1'b1);
    out_ready = 1'b0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl0_out_valid", 256'(out_valid), 256'(0));
    chk("fl0_out_reg_wb", 256'(out_reg_wb), 256'(0));
    chk("fl0_in_ready", 256'(in_ready), 256'(1));
    chk("fl0_retired", 256'(retired), 256'(10));

    to_skid(32'hF0, 32'hF1, 1'b1);
    flush = 1'b1;
    drive(32'hF2, 5'd9, 1'b1);
    out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_out_valid", 256'(out_valid), 256'(0));
    chk("fl1_in_ready", 256'(in_ready), 256'(1));
    chk("fl1_retired", 256'(retired), 256'(11));

    stream(32'h20, 6);
    chk("wrap_retired", 256'(retired), 256'(17));
    chk("wrap_w_retired", 256'(w_retired), 256'(1));

    to_skid(32'h31, 32'h32, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_in_ready", 256'(in_ready), 256'(1));
    chk("arst_retired", 256'(retired), 256'(0));
    chk("arst_w_retired", 256'(w_retired), 256'(0));
    chk("arst_out_data", 256'(out_data), 256'(0));
    chk("arst_out_rd", 256'(out_rd), 256'(0));
    step();
    reset = 1'b1;
    out_ready = 1'b0;
    step();

    for (int c = 0; c < 300; c++) begin
      p_in_valid  = 1'($urandom_range(0, 1));
      p_in_data   = {$urandom, $urandom};
      p_in_rd     = 6'($urandom);
      p_in_reg_wb = 1'($urandom);
      p_out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    p_in_valid  = 1'b0;
    p_out_ready = 1'b1;
    repeat (4) step();
    chk("p_drained_queue", 256'(qp.size()), 256'(0));
    chk("p_out_valid", 256'(p_out_valid), 256'(0));
    chk("p_retired", 256'(p_retired), 256'(p_pops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
